// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use, taken redirects, M-op occupancy.
// Optional HAZARD_PERF_EN adds free-running stall/flush cycle counters.
module hazard_control_unit #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned DIV_LATENCY = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    input  logic       ex_md_valid,
    input  logic       ex_md_is_div,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_bubble,
    output logic       md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   md_lat;
    logic               md_single;
    logic               load_use;
    logic               rs1_hit;
    logic               rs2_hit;

    // Occupancy of the M-op currently in EX, including its issue cycle
    assign md_lat    = ex_md_is_div ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
    assign md_single = (md_lat == CNT_W'(1));

    // x0 never carries a real dependency
    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (!ex_branch_taken && ex_md_valid && !md_single) begin
                    state_d = ST_MD_BUSY;
                    cnt_d   = md_lat - CNT_W'(2);
                end
            end
            ST_MD_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Redirect beats M-op beats load-use; the busy state ignores everything but its counter
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        md_done       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_md_valid) begin
                        if (md_single) begin
                            md_done = 1'b1;
                        end else begin
                            pc_stall      = 1'b1;
                            if_id_stall   = 1'b1;
                            id_ex_stall   = 1'b1;
                            ex_mem_bubble = 1'b1;
                        end
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    if (cnt_q != '0) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        id_ex_stall   = 1'b1;
                        ex_mem_bubble = 1'b1;
                    end else begin
                        md_done = 1'b1;
                    end
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Cycle counters wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(pc_stall);
            perf_flush_cnt <= perf_flush_cnt + PERF_W'(if_id_flush);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle vector table plus multi-cycle M-op/reset sequences.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       ex_md_valid, ex_md_is_div;
    logic       pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, md_done;
    logic       pc_stall1, if_id_stall1, id_ex_stall1, if_id_flush1, id_ex_flush1, ex_mem_bubble1, md_done1;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt1, perf_flush_cnt1;
`endif

    logic [6:0] out_v, out1_v;
    assign out_v  = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_bubble, md_done};
    assign out1_v = {pc_stall1, if_id_stall1, id_ex_stall1, if_id_flush1, id_ex_flush1, ex_mem_bubble1, md_done1};

    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] LU    = 7'b1100100;
    localparam logic [6:0] FLUSH = 7'b0001100;
    localparam logic [6:0] STALL = 7'b1110010;
    localparam logic [6:0] DONE  = 7'b0000001;

    hazard_control_unit #(.MUL_LATENCY(3), .DIV_LATENCY(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_md_valid(ex_md_valid), .ex_md_is_div(ex_md_is_div),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .md_done(md_done)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // Minimum-latency instance: MUL completes in its issue cycle, DIV in two
    hazard_control_unit #(.MUL_LATENCY(1), .DIV_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_md_valid(ex_md_valid), .ex_md_is_div(ex_md_is_div),
        .pc_stall(pc_stall1), .if_id_stall(if_id_stall1), .id_ex_stall(id_ex_stall1),
        .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .ex_mem_bubble(ex_mem_bubble1),
        .md_done(md_done1)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt1), .perf_flush_cnt(perf_flush_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [10];
    int   total;
    int   passed;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic br,
                         input logic mdv, input logic isdiv);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
        ex_md_valid = mdv; ex_md_is_div = isdiv;
    endtask

    task automatic step_check(input string name, input logic [6:0] exp);
        @(negedge clk);
        #1 check(name, out_v, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        vecs[0] = '{rs1: 5'd5,  rs2: 5'd0, u1: 1'b1, u2: 1'b1, rd: 5'd5,  mr: 1'b1, br: 1'b0, exp: LU};
        vecs[1] = '{rs1: 5'd0,  rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: 5'd0,  mr: 1'b1, br: 1'b0, exp: NONE};
        vecs[2] = '{rs1: 5'd5,  rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd5,  mr: 1'b1, br: 1'b0, exp: NONE};
        vecs[3] = '{rs1: 5'd1,  rs2: 5'd7, u1: 1'b1, u2: 1'b1, rd: 5'd7,  mr: 1'b1, br: 1'b0, exp: LU};
        vecs[4] = '{rs1: 5'd1,  rs2: 5'd7, u1: 1'b1, u2: 1'b0, rd: 5'd7,  mr: 1'b1, br: 1'b0, exp: NONE};
        vecs[5] = '{rs1: 5'd5,  rs2: 5'd0, u1: 1'b1, u2: 1'b1, rd: 5'd5,  mr: 1'b0, br: 1'b0, exp: NONE};
        vecs[6] = '{rs1: 5'd5,  rs2: 5'd0, u1: 1'b1, u2: 1'b1, rd: 5'd5,  mr: 1'b1, br: 1'b1, exp: FLUSH};
        vecs[7] = '{rs1: 5'd2,  rs2: 5'd3, u1: 1'b1, u2: 1'b1, rd: 5'd9,  mr: 1'b0, br: 1'b1, exp: FLUSH};
        vecs[8] = '{rs1: 5'd31, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: 5'd31, mr: 1'b1, br: 1'b0, exp: LU};
        vecs[9] = '{rs1: 5'd4,  rs2: 5'd6, u1: 1'b1, u2: 1'b1, rd: 5'd5,  mr: 1'b1, br: 1'b0, exp: NONE};

        // Reset forces every output low even with all hazards asserted
        rst = 1'b1;
        drive(5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        step_check("reset_outputs", NONE);
        @(negedge clk);
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].mr, vecs[i].br,
                  1'b0, 1'b0);
            #1 check($sformatf("vec%0d", i), out_v, vecs[i].exp);
        end

        // DIV: 7 stall cycles (redirect/load-use ignored while busy), done on the 8th
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("div_issue", out_v, STALL);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
            else        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            #1 check($sformatf("div_busy%0d", i), out_v, STALL);
        end
        step_check("div_done", DONE);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("div_after", out_v, NONE);

        // Back-to-back MULs: second issues the cycle after done with no gap
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("mul_a_issue", out_v, STALL);
        step_check("mul_a_busy", STALL);
        step_check("mul_a_done", DONE);
        step_check("mul_b_issue", STALL);
        step_check("mul_b_busy", STALL);
        step_check("mul_b_done", DONE);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("mul_after", out_v, NONE);

        // Reset on the third DIV stall cycle aborts without a done pulse
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("abort_issue", out_v, STALL);
        step_check("abort_busy", STALL);
        @(negedge clk);
        rst = 1'b1;
        #1 check("abort_reset", out_v, NONE);
        @(negedge clk);
        rst = 1'b0;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("abort_run_lu", out_v, LU);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("abort_no_done", out_v, NONE);

        // Latency 1 MUL and latency 2 DIV on the minimum-latency instance
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 check("l1_mul_done", out1_v, DONE);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 check("l2_div_issue", out1_v, STALL);
        @(negedge clk);
        #1 check("l2_div_done", out1_v, DONE);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("l2_after", out1_v, NONE);

`ifdef HAZARD_PERF_EN
        // Load-use (1 stall) + redirect (1 flush) + DIV (7 stalls)
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (perf_stall_cnt !== 32'd8) $display("FAIL perf_stall: got %0d expected 8", perf_stall_cnt);
        else passed++;
        total++;
        if (perf_flush_cnt !== 32'd1) $display("FAIL perf_flush: got %0d expected 1", perf_flush_cnt);
        else passed++;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
